// File: rtl/panel_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : panel_pkg
//  Description : Shared definitions for the HUB75 panel scanner: FSM state
//                encoding, HUB75 timing constants and plane-bit helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package panel_pkg;

    // Scan FSM state encoding
    typedef enum logic [3:0] {
        REQ_TOP  = 4'd0,
        WAIT_TOP = 4'd1,
        REQ_BOT  = 4'd2,
        WAIT_BOT = 4'd3,
        SHIFT_HI = 4'd4,
        SHIFT_LO = 4'd5,
        BLANK    = 4'd6,
        LATCH    = 4'd7,
        SHOW     = 4'd8,
        TICK     = 4'd9
    } panel_state_e;

    // HUB75 control pulse widths in clk cycles
    localparam int unsigned C_LATCH_WIDTH = 1;
    localparam int unsigned C_BLANK_WIDTH = 1;

    // Width of one colour channel returned by the pixel source
    localparam int unsigned C_CHAN_BITS = 8;

    // Channel bit shown during plane p when 'planes' bit-planes are in use:
    // the most significant 'planes' bits of the channel, LSB-plane first.
    function automatic logic [2:0] plane_bit(input int unsigned planes,
                                             input logic [2:0]  p);
        return 3'(C_CHAN_BITS - planes + 32'(p));
    endfunction

endpackage
`default_nettype wire

// File: rtl/panel_bcm_timer.sv
`default_nettype none
// ============================================================================
//  Module      : panel_bcm_timer
//  Description : On-time timer for one bit-plane. Loads BASE<<plane, counts
//                down while enabled and pulses done on the final on-cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module panel_bcm_timer #(
    parameter int BASE  = 8,
    parameter int CNT_W = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       en,
    input  logic [2:0] plane,
    output logic       done
);

    logic [CNT_W-1:0] r_count;

    // Down-counter: load the plane weight, then consume one count per on-cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= CNT_W'(BASE) << plane;
        end else if (en && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    // The cycle holding count 1 is the last on-cycle of the plane
    assign done = en && (r_count == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/panel_scan.sv
`default_nettype none
// ============================================================================
//  Module      : panel_scan
//  Description : HUB75 LED panel scanner. Requests top and bottom pixels from
//                a pixel source, shifts one row into the panel, latches it and
//                shows it for a binary-weighted on-time per bit-plane.
//  Config      : PANEL_SCAN_BCM_EN - when defined, binary-coded modulation
//                over PWM_BITS planes; otherwise one plane (bit 7) per row.
//  Revision    : 1.0 - initial release
// ============================================================================
module panel_scan
    import panel_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int HEIGHT       = 16,
    parameter int PWM_BITS     = 4,
    parameter int DISPLAY_BASE = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          valid,
    output logic                          tick,
    output logic [9:0]                    x,
    output logic [9:0]                    y,
    input  logic                          ready,
    input  logic                          validOut,
    input  logic [7:0]                    red,
    input  logic [7:0]                    green,
    input  logic [7:0]                    blue,
    output logic                          ack,
    output logic                          r0,
    output logic                          g0,
    output logic                          b0,
    output logic                          r1,
    output logic                          g1,
    output logic                          b1,
    output logic                          sclk,
    output logic                          lat,
    output logic                          oe,
    output logic [$clog2(HEIGHT/2)-1:0]   addr
);

`ifdef PANEL_SCAN_BCM_EN
    localparam bit BCM_EN = 1'b1;
`else
    localparam bit BCM_EN = 1'b0;
`endif

    localparam int PLANES = BCM_EN ? PWM_BITS : 1;
    localparam int ROWS   = HEIGHT / 2;
    localparam int COL_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int ROW_W  = $clog2(ROWS);
    localparam int CNT_W  = $clog2((DISPLAY_BASE << (PLANES - 1)) + 1);

    panel_state_e     r_state;
    panel_state_e     w_state_next;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic [2:0]       r_plane;
    logic [1:0]       r_hold;
    logic             w_hold_done;
    logic             w_show_done;
    logic             w_last_col;
    logic             w_last_row;
    logic             w_last_plane;
    logic [2:0]       w_bit;

    assign w_last_col   = (r_col == COL_W'(WIDTH - 1));
    assign w_last_row   = (r_row == ROW_W'(ROWS - 1));
    assign w_last_plane = (r_plane == 3'(PLANES - 1));
    assign w_bit        = plane_bit(PLANES, r_plane);

    panel_bcm_timer #(
        .BASE  (DISPLAY_BASE),
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (r_state == LATCH),
        .en    (r_state == SHOW),
        .plane (r_plane),
        .done  (w_show_done)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= REQ_TOP;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and per-state strobes
    always_comb begin
        w_state_next = r_state;
        valid        = 1'b0;
        tick         = 1'b0;
        ack          = 1'b0;
        sclk         = 1'b0;
        lat          = 1'b0;
        oe           = 1'b1;
        x            = 10'(r_col);
        y            = 10'(r_row);
        w_hold_done  = 1'b0;
        case (r_state)
            REQ_TOP: begin
                if (ready) begin
                    valid        = 1'b1;
                    w_state_next = WAIT_TOP;
                end
            end
            WAIT_TOP: begin
                if (validOut) begin
                    ack          = 1'b1;
                    w_state_next = REQ_BOT;
                end
            end
            REQ_BOT: begin
                y = 10'(r_row) + 10'(ROWS);
                if (ready) begin
                    valid        = 1'b1;
                    w_state_next = WAIT_BOT;
                end
            end
            WAIT_BOT: begin
                if (validOut) begin
                    ack          = 1'b1;
                    w_state_next = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                sclk         = 1'b1;
                w_state_next = SHIFT_LO;
            end
            SHIFT_LO: begin
                w_state_next = w_last_col ? BLANK : REQ_TOP;
            end
            BLANK: begin
                w_hold_done = (r_hold == 2'(C_BLANK_WIDTH - 1));
                if (w_hold_done) begin
                    w_state_next = LATCH;
                end
            end
            LATCH: begin
                lat         = 1'b1;
                w_hold_done = (r_hold == 2'(C_LATCH_WIDTH - 1));
                if (w_hold_done) begin
                    w_state_next = SHOW;
                end
            end
            SHOW: begin
                oe = 1'b0;
                if (w_show_done) begin
                    w_state_next = (w_last_plane && w_last_row) ? TICK : REQ_TOP;
                end
            end
            TICK: begin
                if (ready) begin
                    valid        = 1'b1;
                    tick         = 1'b1;
                    w_state_next = REQ_TOP;
                end
            end
            default: begin
                w_state_next = REQ_TOP;
            end
        endcase
    end

    // Scan position, pixel capture, row address and pulse-width hold counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col   <= '0;
            r_row   <= '0;
            r_plane <= '0;
            r_hold  <= '0;
            addr    <= '0;
            r0      <= 1'b0;
            g0      <= 1'b0;
            b0      <= 1'b0;
            r1      <= 1'b0;
            g1      <= 1'b0;
            b1      <= 1'b0;
        end else begin
            if (((r_state == BLANK) || (r_state == LATCH)) && !w_hold_done) begin
                r_hold <= r_hold + 2'd1;
            end else begin
                r_hold <= '0;
            end

            if ((r_state == WAIT_TOP) && validOut) begin
                r0 <= red[w_bit];
                g0 <= green[w_bit];
                b0 <= blue[w_bit];
            end
            if ((r_state == WAIT_BOT) && validOut) begin
                r1 <= red[w_bit];
                g1 <= green[w_bit];
                b1 <= blue[w_bit];
            end

            if (r_state == SHIFT_LO) begin
                r_col <= w_last_col ? '0 : r_col + COL_W'(1);
            end

            if (r_state == BLANK) begin
                addr <= r_row;
            end

            // Same row is re-fetched for every plane; the row only moves on
            // once its last plane has been shown.
            if ((r_state == SHOW) && w_show_done) begin
                if (w_last_plane) begin
                    r_plane <= '0;
                    if (!w_last_row) begin
                        r_row <= r_row + ROW_W'(1);
                    end
                end else begin
                    r_plane <= r_plane + 3'd1;
                end
            end

            if ((r_state == TICK) && ready) begin
                r_row <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_panel_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_panel_scan
//  Description : Self-checking bench for panel_scan on a 4x4 panel with a
//                pixel source that answers one cycle after each request.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_panel_scan;

    localparam int WIDTH        = 4;
    localparam int HEIGHT       = 4;
    localparam int PWM_BITS     = 4;
    localparam int DISPLAY_BASE = 8;
    localparam int ROWS         = HEIGHT / 2;
`ifdef PANEL_SCAN_BCM_EN
    localparam int PLANES = PWM_BITS;
`else
    localparam int PLANES = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ready = 1'b0;
    logic       validOut = 1'b0;
    logic [7:0] red = 8'h00;
    logic [7:0] green = 8'h00;
    logic [7:0] blue = 8'h00;
    logic       valid, tick, ack;
    logic [9:0] x, y;
    logic       r0, g0, b0, r1, g1, b1;
    logic       sclk, lat, oe;
    logic [0:0] addr;

    always #5 clk = ~clk;

    panel_scan #(
        .WIDTH        (WIDTH),
        .HEIGHT       (HEIGHT),
        .PWM_BITS     (PWM_BITS),
        .DISPLAY_BASE (DISPLAY_BASE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .valid    (valid),
        .tick     (tick),
        .x        (x),
        .y        (y),
        .ready    (ready),
        .validOut (validOut),
        .red      (red),
        .green    (green),
        .blue     (blue),
        .ack      (ack),
        .r0       (r0),
        .g0       (g0),
        .b0       (b0),
        .r1       (r1),
        .g1       (g1),
        .b1       (b1),
        .sclk     (sclk),
        .lat      (lat),
        .oe       (oe),
        .addr     (addr)
    );

    // Pixel colour vector: top colour, whether the bottom half gets the
    // inverted colour, expected top bits per plane (BCM) and expected top
    // bits {r,g,b} for the single-plane build.
    typedef struct {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       inv;
        logic [3:0] mr;
        logic [3:0] mg;
        logic [3:0] mb;
        logic [2:0] off;
    } vec_t;

    vec_t vecs[4];
    vec_t cur;

    int   n_chk = 0;
    int   n_fail = 0;
    int   lat_total = 0;
    int   req_idx = 0;
    int   run_len = 0;
    int   sclk_cnt = 0;
    int   runs_done = 0;
    int   tick_cnt = 0;
    logic pv = 1'b0;
    logic ptk = 1'b0;
    logic ready_q = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs after the edge, then sample and check
    task automatic step();
        logic       rst_edge;
        logic [2:0] exp_top;
        logic [2:0] exp_bot;
        rst_edge = rst;
        @(posedge clk);
        #1;
        ready    = ready_q;
        validOut = pv;
        #1;
        if (rst_edge) begin
            chk("ack_after_rst", ack, 0);
            lat_total = 0;
            req_idx   = 0;
            run_len   = 0;
            sclk_cnt  = 0;
            runs_done = 0;
            pv        = 1'b0;
            ptk       = 1'b0;
            return;
        end
        chk("ack", ack, (pv && !ptk) ? 1 : 0);
        if (tick) chk("tick_needs_valid", valid, 1);
        if (!oe) chk("no_sclk_lat_while_on", {sclk, lat}, 0);
        if (sclk) begin
`ifdef PANEL_SCAN_BCM_EN
            begin
                int plane;
                plane   = lat_total % PLANES;
                exp_top = {cur.mr[plane], cur.mg[plane], cur.mb[plane]};
            end
`else
            exp_top = cur.off;
`endif
            exp_bot = cur.inv ? ~exp_top : exp_top;
            chk("data_top", {r0, g0, b0}, exp_top);
            chk("data_bot", {r1, g1, b1}, exp_bot);
            sclk_cnt++;
        end
        if (lat) begin
            chk("sclk_before_lat", sclk_cnt, WIDTH);
            chk("addr", addr, lat_total / PLANES);
            sclk_cnt = 0;
            lat_total++;
            req_idx = 0;
        end
        if (!oe) begin
            run_len++;
        end else if (run_len > 0) begin
            chk("oe_run", run_len, DISPLAY_BASE << ((lat_total - 1) % PLANES));
            run_len = 0;
            runs_done++;
        end
        if (valid && !tick) begin
            chk("req_x", x, req_idx / 2);
            chk("req_y", y, (lat_total / PLANES) + (req_idx % 2) * ROWS);
            req_idx++;
            if ((y >= 10'(ROWS)) && cur.inv) begin
                red = ~cur.r; green = ~cur.g; blue = ~cur.b;
            end else begin
                red = cur.r; green = cur.g; blue = cur.b;
            end
        end
        if (valid && tick) begin
            chk("frame_complete", lat_total, ROWS * PLANES);
            lat_total = 0;
            req_idx   = 0;
            tick_cnt++;
        end
        pv  = valid;
        ptk = tick;
    endtask

    initial begin
        vecs[0] = '{r:8'h80, g:8'h10, b:8'hA0, inv:1'b1, mr:4'b1000, mg:4'b0001, mb:4'b1010, off:3'b101};
        vecs[1] = '{r:8'h0F, g:8'hF0, b:8'h55, inv:1'b1, mr:4'b0000, mg:4'b1111, mb:4'b0101, off:3'b010};
        vecs[2] = '{r:8'h30, g:8'hC0, b:8'h00, inv:1'b1, mr:4'b0011, mg:4'b1100, mb:4'b0000, off:3'b010};
        vecs[3] = '{r:8'h80, g:8'h80, b:8'h80, inv:1'b0, mr:4'b1000, mg:4'b1000, mb:4'b1000, off:3'b111};
        cur = vecs[0];

        // Reset state
        rst = 1'b1;
        ready_q = 1'b0;
        step();
        step();
        chk("reset_state", {valid, tick, ack, x, y, r0, g0, b0, r1, g1, b1, sclk, lat, oe, addr}, 2);
        rst = 1'b0;

        // Request held while the source is not ready
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_valid", valid, 0);
            chk("stall_xy", {x, y}, 0);
        end
        ready_q = 1'b1;
        step();
        chk("stall_release", valid, 1);
        step();
        chk("single_pulse", valid, 0);

        // Colour vectors: one full row (all planes) each, monitor checks data
        for (int i = 0; i < 4; i++) begin
            cur = vecs[i];
            rst = 1'b1;
            ready_q = 1'b0;
            step();
            rst = 1'b0;
            ready_q = 1'b1;
            for (int g = 0; g < 2000 && runs_done < PLANES; g++) step();
            chk("row0_planes_done", runs_done, PLANES);
        end

        // Finish the frame, stalling the tick for a few cycles
        for (int g = 0; g < 3000 && !(lat_total == ROWS * PLANES && !oe); g++) step();
        chk("reach_last_show", (lat_total == ROWS * PLANES && !oe) ? 1 : 0, 1);
        ready_q = 1'b0;
        for (int g = 0; g < 200 && !oe; g++) step();
        chk("last_show_ends", oe, 1);
        for (int i = 0; i < 3; i++) begin
            chk("tick_held", {valid, tick}, 0);
            step();
        end
        ready_q = 1'b1;
        step();
        chk("tick_pulse", {valid, tick}, 3);
        step();
        chk("first_req_after_tick", {valid, tick, x, y}, 2 ** 21);
        chk("tick_count", tick_cnt, 1);

        // Reset while row 1 is being shown
        for (int g = 0; g < 3000 && !(lat_total == PLANES + 1 && !oe); g++) step();
        chk("reach_row1_show", (lat_total == PLANES + 1 && !oe) ? 1 : 0, 1);
        chk("addr_row1", addr, 1);
        rst = 1'b1;
        ready_q = 1'b0;
        step();
        chk("rst_show", {oe, addr, valid}, 4);
        rst = 1'b0;
        ready_q = 1'b1;
        step();
        chk("req_after_rst", {valid, x, y}, 2 ** 20);

        // Reset while waiting for the pixel: the late pixel is not acked
        rst = 1'b1;
        ready_q = 1'b0;
        step();
        rst = 1'b0;
        step();
        chk("idle_after_wait_rst", {valid, ack}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
